// File: rtl/proc_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, grant selects and default widths.
package proc_pkg;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        GNT_FE  = 1'b0,
        GNT_MEM = 1'b1
    } gnt_e;

endpackage

// File: rtl/arb_pick.sv
// Grant selection between FE and MEM: MEM first, except that FE is forced through once
// MEM has won MAX_STREAK consecutive grants while a fetch was waiting.
module arb_pick
    import proc_pkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample,
    input  logic fe_req,
    input  logic fe_flush,
    input  logic mem_req,
    output logic gnt_valid,
    output gnt_e gnt
);

    localparam int SW = $clog2(MAX_STREAK + 1);

    logic [SW-1:0] streak_q;
    logic [SW-1:0] streak_d;
    logic          fe_forced;

    always_comb begin
        fe_forced = fe_req && (streak_q == SW'(MAX_STREAK));
        gnt_valid = 1'b0;
        gnt       = GNT_FE;
        if (mem_req && !fe_forced) begin
            gnt_valid = 1'b1;
            gnt       = GNT_MEM;
        end else if (fe_req && !fe_flush) begin
            gnt_valid = 1'b1;
            gnt       = GNT_FE;
        end
    end

    // The streak only moves on cycles where the top is actually sampling requests (IDLE).
    always_comb begin
        streak_d = streak_q;
        if (sample) begin
            if (!fe_req) begin
                streak_d = '0;
            end else if (gnt_valid && (gnt == GNT_FE)) begin
                streak_d = '0;
            end else if (gnt_valid && (gnt == GNT_MEM) && (streak_q != SW'(MAX_STREAK))) begin
                streak_d = streak_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises FE fetches and MEM loads/stores onto one single-port RAM and returns
// results with one-cycle ack pulses; a fetch flushed mid-flight completes silently.
module mem_port_arbiter
    import proc_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int RAM_LAT    = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic          CLOCK_50,
    input  logic          reset_n,
    input  logic          fe_req,
    input  logic [AW-1:0] fe_addr,
    input  logic          fe_flush,
    output logic [DW-1:0] fe_rdata,
    output logic          fe_ack,
    output logic          fe_stall,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic [DW-1:0] mem_rdata,
    output logic          mem_ack,
    output logic          mem_stall,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam int CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RAM_LAT - 1);

    state_e        state_q, state_d;
    gnt_e          gnt_q, gnt_d;
    logic          we_q, we_d;
    logic          drop_q, drop_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ram_en_q, ram_en_d;
    logic          ram_we_q, ram_we_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdata_q, ram_wdata_d;
    logic [DW-1:0] fe_rdata_q, fe_rdata_d;
    logic [DW-1:0] mem_rdata_q, mem_rdata_d;

    logic pick_valid;
    gnt_e pick_gnt;

    arb_pick #(
        .MAX_STREAK(MAX_STREAK)
    ) u_pick (
        .clk      (CLOCK_50),
        .rst_n    (reset_n),
        .sample   (state_q == ST_IDLE),
        .fe_req   (fe_req),
        .fe_flush (fe_flush),
        .mem_req  (mem_req),
        .gnt_valid(pick_valid),
        .gnt      (pick_gnt)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= GNT_FE;
            we_q        <= 1'b0;
            drop_q      <= 1'b0;
            cnt_q       <= '0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            fe_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            drop_q      <= drop_d;
            cnt_q       <= cnt_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            fe_rdata_q  <= fe_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pick_valid) state_d = ST_ISSUE;
            ST_ISSUE: state_d = we_q ? ST_RESP : ST_WAIT;
            ST_WAIT:  if (cnt_q == CNT_LAST) state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // RAM strobes are precomputed in IDLE so they leave the flops cleanly during ISSUE.
    always_comb begin
        gnt_d       = gnt_q;
        we_d        = we_q;
        drop_d      = drop_q;
        cnt_d       = cnt_q;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        fe_rdata_d  = fe_rdata_q;
        mem_rdata_d = mem_rdata_q;

        if ((state_q != ST_IDLE) && (gnt_q == GNT_FE) && fe_flush) begin
            drop_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    gnt_d    = pick_gnt;
                    we_d     = (pick_gnt == GNT_MEM) && mem_we;
                    drop_d   = 1'b0;
                    cnt_d    = '0;
                    ram_en_d = 1'b1;
                    ram_we_d = (pick_gnt == GNT_MEM) && mem_we;
                    ram_addr_d = (pick_gnt == GNT_MEM) ? mem_addr : fe_addr;
                    if ((pick_gnt == GNT_MEM) && mem_we) begin
                        ram_wdata_d = mem_wdata;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    if (gnt_q == GNT_MEM) begin
                        mem_rdata_d = ram_rdata;
                    end else if (!(drop_q || fe_flush)) begin
                        fe_rdata_d = ram_rdata;
                    end
                end
            end
            ST_RESP: begin
                drop_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        fe_ack    = (state_q == ST_RESP) && (gnt_q == GNT_FE) && !drop_q && !fe_flush;
        mem_ack   = (state_q == ST_RESP) && (gnt_q == GNT_MEM);
        fe_stall  = fe_req && !fe_ack;
        mem_stall = mem_req && !mem_ack;
        fe_rdata  = fe_rdata_q;
        mem_rdata = mem_rdata_q;
        ram_en    = ram_en_q;
        ram_we    = ram_we_q;
        ram_addr  = ram_addr_q;
        ram_wdata = ram_wdata_q;
    end

endmodule
